// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory-stage bus block:
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD)
//   - FSM state enumeration (IDLE, LOAD, DONE)
//   - byteEnable  : byte-lane write mask for a store
//   - storeLanes  : replicates right-aligned store data across the word
//   - loadExtract : picks the addressed lane from a RAM word and extends it
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    DONE = 2'b10
  } memState_e;

  // Write mask for a store; lowAddr must already be size-aligned.
  function automatic logic [3:0] byteEnable(input logic [1:0] size,
                                            input logic [1:0] lowAddr);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lowAddr;
      SZ_HALF: be = lowAddr[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data is right-aligned on the bus; copying it into every lane lets
  // the byte enables alone decide which lane lands in memory.
  function automatic logic [31:0] storeLanes(input logic [1:0]  size,
                                             input logic [31:0] wdata);
    logic [31:0] lanes;
    case (size)
      SZ_BYTE: lanes = {4{wdata[7:0]}};
      SZ_HALF: lanes = {2{wdata[15:0]}};
      SZ_WORD: lanes = wdata;
      default: lanes = 32'h0000_0000;
    endcase
    return lanes;
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
  // Word loads ignore isUnsigned.
  function automatic logic [31:0] loadExtract(input logic [1:0]  size,
                                              input logic        isUnsigned,
                                              input logic [1:0]  lowAddr,
                                              input logic [31:0] dout);
    logic [31:0] shifted;
    logic [31:0] res;
    shifted = 32'h0000_0000;
    case (size)
      SZ_BYTE: begin
        shifted = dout >> {lowAddr, 3'b000};
        res     = {{24{~isUnsigned & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        shifted = dout >> {lowAddr[1], 4'b0000};
        res     = {{16{~isUnsigned & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: res = dout;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_stage_ram.sv
// -----------------------------------------------------------------------------
// mem_stage_ram
// Single-port 32-bit RAM, 2**DEPTH_LOG2 words, four byte write enables and a
// registered read port. A read and a write to the same address in one cycle
// returns the old contents. The array starts uninitialised.
// Ports:
//   clk    in   rising-edge clock
//   addr   in   word index
//   be     in   per-byte write enables (any bit set performs a write)
//   wdata  in   write data, already lane-replicated
//   re     in   read enable; rdata holds its value when low
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module mem_stage_ram
  import mem_stage_pkg::*;
#(
  parameter int    DEPTH_LOG2 = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [3:0]            be,
  input  logic [31:0]           wdata,
  input  logic                  re,
  output logic [31:0]           rdata
);

  logic [31:0] mem_r [0:(1 << DEPTH_LOG2) - 1];
  logic [31:0] rdata_r;

  // Byte-lane write port.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Registered read port; holds the last word read while re is low.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_stage_bus.sv
// -----------------------------------------------------------------------------
// mem_stage_bus
// Data-memory pipeline stage with byte/half/word loads and stores, a
// valid/ready request port and a registered one-cycle response pulse.
// Stores and rejected requests answer one cycle after acceptance; loads answer
// two cycles after acceptance because the RAM read is registered.
//
// Build option: MEM_STAGE_ALIGN_CHECK_EN
//   defined   - misaligned half/word requests are rejected with resp_err
//   undefined - misaligned requests are forced to alignment and performed
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high
//   req_valid     in   request present
//   req_ready     out  block accepts a request this cycle (IDLE only)
//   req_we        in   1 = store, 0 = load
//   req_size      in   00 byte, 01 half, 10 word, 11 reserved (error)
//   req_unsigned  in   loads: 1 = zero-extend, 0 = sign-extend
//   req_addr      in   byte address; bits above the RAM size wrap
//   req_wdata     in   right-aligned store data
//   resp_valid    out  one-cycle completion pulse
//   resp_rdata    out  extended load data; 0 for stores and errors
//   resp_err      out  request rejected, RAM untouched
// -----------------------------------------------------------------------------
module mem_stage_bus
  import mem_stage_pkg::*;
#(
  parameter int    DEPTH_LOG2 = 10,
  parameter int    ADDR_WIDTH = 32,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
);

  memState_e state_r;
  memState_e nextState_s;

  logic        ready_r;
  logic        respValid_r;
  logic        respErr_r;
  logic [31:0] respRdata_r;

  logic        nextValid_s;
  logic        nextErr_s;
  logic [31:0] nextRdata_s;

  // Load attributes captured at accept; the request bus is free afterwards.
  logic [1:0]  latSize_r;
  logic        latUnsigned_r;
  logic [1:0]  latLow_r;

  logic        accept_s;
  logic        sizeErr_s;
  logic        alignErr_s;
  logic        reqErr_s;
  logic [1:0]  effLow_s;

  logic [DEPTH_LOG2-1:0] wordIdx_s;
  logic                  ramWe_s;
  logic                  ramRe_s;
  logic [3:0]            ramBe_s;
  logic [31:0]           ramWdata_s;
  logic [31:0]           ramDout_s;

  // High address bits only alias the RAM; they are intentionally dropped.
  logic unusedAddr_s;
  assign unusedAddr_s = ^req_addr[ADDR_WIDTH-1:DEPTH_LOG2+2];

  assign accept_s  = req_valid & ready_r;
  assign wordIdx_s = req_addr[DEPTH_LOG2+1:2];

  // Classify the request and derive the low address bits actually used.
  always_comb begin
    sizeErr_s  = (req_size == SZ_RSVD);
    alignErr_s = 1'b0;
    effLow_s   = req_addr[1:0];
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    if (req_size == SZ_HALF) begin
      alignErr_s = req_addr[0];
    end else if (req_size == SZ_WORD) begin
      alignErr_s = (req_addr[1:0] != 2'b00);
    end else begin
      alignErr_s = 1'b0;
    end
`else
    if (req_size == SZ_HALF) begin
      effLow_s = {req_addr[1], 1'b0};
    end else if (req_size == SZ_WORD) begin
      effLow_s = 2'b00;
    end else begin
      effLow_s = req_addr[1:0];
    end
`endif
    reqErr_s = sizeErr_s | alignErr_s;
  end

  // A request arriving together with reset must leave memory untouched,
  // hence the reset term in both RAM strobes.
  assign ramWe_s    = accept_s & req_we & ~reqErr_s & ~reset;
  assign ramRe_s    = accept_s & ~req_we & ~reqErr_s & ~reset;
  assign ramBe_s    = ramWe_s ? byteEnable(req_size, effLow_s) : 4'b0000;
  assign ramWdata_s = storeLanes(req_size, req_wdata);

  mem_stage_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .addr  (wordIdx_s),
    .be    (ramBe_s),
    .wdata (ramWdata_s),
    .re    (ramRe_s),
    .rdata (ramDout_s)
  );

  // Next state and next response values; responses default to zero so the
  // outputs drop back to 0 whenever the FSM leaves DONE.
  always_comb begin
    nextState_s = state_r;
    nextValid_s = 1'b0;
    nextErr_s   = 1'b0;
    nextRdata_s = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (reqErr_s) begin
            nextState_s = DONE;
            nextValid_s = 1'b1;
            nextErr_s   = 1'b1;
          end else if (req_we) begin
            nextState_s = DONE;
            nextValid_s = 1'b1;
          end else begin
            nextState_s = LOAD;
          end
        end else begin
          nextState_s = IDLE;
        end
      end
      LOAD: begin
        nextState_s = DONE;
        nextValid_s = 1'b1;
        nextRdata_s = loadExtract(latSize_r, latUnsigned_r, latLow_r, ramDout_s);
      end
      DONE: begin
        nextState_s = IDLE;
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // State register and registered response/handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      ready_r     <= 1'b1;
      respValid_r <= 1'b0;
      respErr_r   <= 1'b0;
      respRdata_r <= 32'h0000_0000;
    end else begin
      state_r     <= nextState_s;
      ready_r     <= (nextState_s == IDLE);
      respValid_r <= nextValid_s;
      respErr_r   <= nextErr_s;
      respRdata_r <= nextRdata_s;
    end
  end

  // Capture load attributes needed one cycle later for lane selection.
  always_ff @(posedge clk) begin
    if (reset) begin
      latSize_r     <= SZ_WORD;
      latUnsigned_r <= 1'b0;
      latLow_r      <= 2'b00;
    end else if (ramRe_s) begin
      latSize_r     <= req_size;
      latUnsigned_r <= req_unsigned;
      latLow_r      <= effLow_s;
    end
  end

  assign req_ready  = ready_r;
  assign resp_valid = respValid_r;
  assign resp_err   = respErr_r;
  assign resp_rdata = respRdata_r;

endmodule

// File: tb/tb_mem_stage_bus.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_bus
// Self-checking bench: directed vector table, reset corner sequences,
// randomized traffic against a byte-array reference model, and a held-valid
// back-to-back handshake sequence.
// -----------------------------------------------------------------------------
module tb_mem_stage_bus;

  localparam int DEPTH_LOG2 = 10;
  localparam int ADDR_WIDTH = 32;
  localparam int RAM_BYTES  = 4 << DEPTH_LOG2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl [0:RAM_BYTES-1];

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        expErr;
    logic [31:0] expRd;
    int          expLat;
  } vec_t;

  vec_t tbl[$];

  mem_stage_bus #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  ("")
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic void addVec(input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic expErr, input logic [31:0] expRd, input int expLat);
    vec_t v;
    v.we = we; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd;
    v.expErr = expErr; v.expRd = expRd; v.expLat = expLat;
    tbl.push_back(v);
  endfunction

  // Reference model: memory as a flat byte array, little-endian.
  function automatic void mdlAccess(input vec_t v, output logic [31:0] rd,
                                    output logic er, output int lat);
    int          n;
    int          a;
    logic [31:0] val;
    er = (v.sz == 2'b11);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    if (v.sz == 2'b01 && v.addr[0]) er = 1'b1;
    if (v.sz == 2'b10 && v.addr[1:0] != 2'b00) er = 1'b1;
`endif
    rd  = 32'h0;
    lat = 1;
    if (!er) begin
      n = 1 << v.sz;
      a = int'(v.addr % RAM_BYTES);
      a = a - (a % n);
      if (v.we) begin
        for (int i = 0; i < n; i++) mdl[a+i] = v.wd[8*i +: 8];
      end else begin
        val = 32'h0;
        for (int i = 0; i < n; i++) val = val | ({24'h0, mdl[a+i]} << (8*i));
        if (!v.uns && n < 4 && val[8*n-1]) val = val | ~((32'd1 << (8*n)) - 32'd1);
        rd  = val;
        lat = 2;
      end
    end
  endfunction

  task automatic drive(input vec_t v);
    req_we       = v.we;
    req_size     = v.sz;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wd;
  endtask

  // Issue one request from a negedge, wait (bounded) for the response,
  // then check that the pulse lasts one cycle and ready returns.
  task automatic doReq(input vec_t v, input string tag,
                       output logic [31:0] rd, output logic er, output int lat);
    int w;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    drive(v);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    if (!resp_valid) begin
      lat = -1;
    end else begin
      @(negedge clk);
      chk({tag, "_pulse"}, {31'h0, resp_valid}, 32'd0);
      chk({tag, "_ready"}, {31'h0, req_ready}, 32'd1);
    end
  endtask

  task automatic runModel(input vec_t v, input string tag);
    logic [31:0] mr;
    logic        me;
    int          ml;
    logic [31:0] rd;
    logic        er;
    int          lat;
    mdlAccess(v, mr, me, ml);
    doReq(v, tag, rd, er, lat);
    chk({tag, "_lat"}, lat, ml);
    chk({tag, "_err"}, {31'h0, er}, {31'h0, me});
    chk({tag, "_rdata"}, rd, mr);
  endtask

  task automatic handshakeTest();
    vec_t        hs[3];
    logic [31:0] qRd[$];
    logic        qErr[$];
    int          acceptCyc[3];
    int          idx;
    int          rsp;
    logic        willAccept;
    logic [31:0] mr;
    logic        me;
    int          ml;
    hs[0] = '{we: 1'b0, sz: 2'b11, uns: 1'b0, addr: 32'h40, wd: 32'h0,
              expErr: 1'b0, expRd: 32'h0, expLat: 0};
    hs[1] = '{we: 1'b1, sz: 2'b00, uns: 1'b0, addr: 32'h41, wd: 32'h77,
              expErr: 1'b0, expRd: 32'h0, expLat: 0};
    hs[2] = '{we: 1'b0, sz: 2'b10, uns: 1'b0, addr: 32'h40, wd: 32'h0,
              expErr: 1'b0, expRd: 32'h0, expLat: 0};
    idx = 0;
    rsp = 0;
    for (int i = 0; i < 3; i++) acceptCyc[i] = -1;
    drive(hs[0]);
    req_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && rsp < 3; cyc++) begin
      willAccept = req_valid & req_ready;
      if (resp_valid) begin
        if (qRd.size() == 0) begin
          chk("hs_spurious_resp", {31'h0, resp_valid}, 32'd0);
        end else begin
          chk($sformatf("hs_rdata%0d", rsp), resp_rdata, qRd.pop_front());
          chk($sformatf("hs_err%0d", rsp), {31'h0, resp_err}, {31'h0, qErr.pop_front()});
          rsp++;
        end
      end
      if (willAccept) begin
        mdlAccess(hs[idx], mr, me, ml);
        qRd.push_back(mr);
        qErr.push_back(me);
        acceptCyc[idx] = cyc;
      end
      @(posedge clk);
      #1;
      if (willAccept) begin
        idx++;
        if (idx < 3) drive(hs[idx]);
        else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("hs_accepts", idx, 32'd3);
    chk("hs_resps", rsp, 32'd3);
    chk("hs_acc0_cycle", acceptCyc[0], 32'd0);
    chk("hs_acc1_cycle", acceptCyc[1], 32'd2);
    chk("hs_acc2_cycle", acceptCyc[2], 32'd4);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    vec_t        v;

    for (int i = 0; i < RAM_BYTES; i++) mdl[i] = 8'h00;

    reset        = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'd1);
    chk("rst_valid", {31'h0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'h0, resp_err}, 32'd0);

    // Directed vectors: we, size, unsigned, addr, wdata, expErr, expRdata, expLatency
    addVec(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1);
    addVec(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2);
    addVec(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, 1'b0, 32'h0, 1);
    addVec(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADAAEF, 2);
    addVec(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, 32'hFFFFFFAA, 2);
    addVec(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, 32'h000000AA, 2);
    addVec(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 1'b0, 32'h0, 1);
    addVec(1'b1, 2'b01, 1'b0, 32'h22, 32'h00008001, 1'b0, 32'h0, 1);
    addVec(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b0, 32'hFFFF8001, 2);
    addVec(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0, 32'h00008001, 2);
    addVec(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h80015678, 2);
    addVec(1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1);
    addVec(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1);
    addVec(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADAAEF, 2);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    addVec(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0, 1);
    addVec(1'b0, 2'b01, 1'b0, 32'h23, 32'h0, 1'b1, 32'h0, 1);
    addVec(1'b1, 2'b10, 1'b0, 32'h12, 32'h0, 1'b1, 32'h0, 1);
`else
    addVec(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b0, 32'hDEADAAEF, 2);
    addVec(1'b0, 2'b01, 1'b0, 32'h23, 32'h0, 1'b0, 32'hFFFF8001, 2);
`endif
    addVec(1'b0, 2'b10, 1'b0, 32'h1010, 32'h0, 1'b0, 32'hDEADAAEF, 2);
    addVec(1'b1, 2'b10, 1'b0, 32'hFFFFF010, 32'hCAFEF00D, 1'b0, 32'h0, 1);
    addVec(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hCAFEF00D, 2);
    addVec(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFFFFCA, 2);
    addVec(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, 32'h0000F00D, 2);

    for (int i = 0; i < tbl.size(); i++) begin
      doReq(tbl[i], $sformatf("vec%0d", i), rd, er, lat);
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].expLat);
      chk($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, tbl[i].expErr});
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].expRd);
    end

    // A store presented while reset is high must be discarded.
    reset = 1'b1;
    v = '{we: 1'b1, sz: 2'b10, uns: 1'b0, addr: 32'h10, wd: 32'h0,
          expErr: 1'b0, expRd: 32'h0, expLat: 0};
    drive(v);
    req_valid = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstacc_valid", {31'h0, resp_valid}, 32'd0);
    v.we = 1'b0;
    doReq(v, "rstacc_load", rd, er, lat);
    chk("rstacc_rdata", rd, 32'hCAFEF00D);

    // Reset while a load is in flight: no response, ready next cycle.
    drive(v);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstload_ready", {31'h0, req_ready}, 32'd1);
    chk("rstload_valid", {31'h0, resp_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rstload_quiet%0d", i), {31'h0, resp_valid}, 32'd0);
    end
    doReq(v, "rstload_after", rd, er, lat);
    chk("rstload_data", rd, 32'hCAFEF00D);
    chk("rstload_lat", lat, 32'd2);

    // Random traffic over the first 64 words, upper address bits randomized.
    for (int w = 0; w < 64; w++) begin
      v = '{we: 1'b1, sz: 2'b10, uns: 1'b0, addr: 32'(w * 4), wd: $urandom(),
            expErr: 1'b0, expRd: 32'h0, expLat: 0};
      runModel(v, $sformatf("init%0d", w));
    end
    for (int k = 0; k < 300; k++) begin
      v.we   = 1'($urandom_range(0, 1));
      v.sz   = 2'($urandom_range(0, 3));
      v.uns  = 1'($urandom_range(0, 1));
      v.addr = $urandom() & 32'hFFFF_F0FF;
      v.wd   = $urandom();
      runModel(v, $sformatf("rnd%0d", k));
    end

    handshakeTest();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
